// File: rtl/fully_associative_register_if.sv
// fully_associative_register_if: shared SI write bus seen by every configuration register
interface fully_associative_register_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] si_addr;
  logic [DATA_WIDTH-1:0] si_data;
  logic                  si_rdy;
  logic                  si_ack;
  modport master (output si_addr, si_data, si_rdy, input si_ack);
  modport slave  (input si_addr, si_data, si_rdy, output si_ack);
endinterface

// File: rtl/fully_associative_register.sv
// fully_associative_register: self-decoding config register that loads SI write data on an address hit
module fully_associative_register #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] MY_ADDR = '0,
  parameter logic [DATA_WIDTH-1:0] MY_RESET_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  fully_associative_register_if.slave   si,
  output logic [DATA_WIDTH-1:0]         data
);
  logic hit;
  assign hit = si.si_addr == MY_ADDR;
  assign si.si_ack = si.si_rdy & hit & ~rst;
  always_ff @(posedge clk or posedge rst)
    if (rst) data <= MY_RESET_VALUE;
    else if (si.si_ack) data <= si.si_data;
endmodule

// File: tb/tb_fully_associative_register.sv
// tb_fully_associative_register: vector table plus data scoreboard for the self-decoding config register
module tb_fully_associative_register;
  localparam logic [7:0] ADDR = 8'h03;
  localparam logic [7:0] RV = 8'hA5;
  typedef struct {
    string      name;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       rdy;
    logic       ack;
  } vec_t;
  logic clk = 0, clk_en = 0, rst = 0;
  logic [7:0] data;
  logic [7:0] model;
  logic [7:0] exp_q[$];
  int checks = 0, errors = 0;
  vec_t vecs[12];
  fully_associative_register_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus();
  fully_associative_register #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .MY_ADDR(ADDR), .MY_RESET_VALUE(RV)
  ) dut (.clk(clk), .rst(rst), .si(bus), .data(data));
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [7:0] a, input logic [7:0] d, input logic r);
    bus.si_addr = a;
    bus.si_data = d;
    bus.si_rdy = r;
  endtask
  task automatic step(input vec_t v);
    @(negedge clk);
    drive(v.addr, v.wdata, v.rdy);
    #1;
    chk({v.name, " ack"}, {7'd0, bus.si_ack}, {7'd0, v.ack});
    if (v.rdy && v.addr == ADDR) model = v.wdata;
    exp_q.push_back(model);
    @(posedge clk);
    #1;
    chk({v.name, " data"}, data, exp_q.pop_front());
  endtask
  initial begin
    vecs = '{
      '{"hit",      8'h03, 8'h5C, 1'b1, 1'b1},
      '{"idle",     8'h03, 8'h5C, 1'b0, 1'b0},
      '{"miss0",    8'h04, 8'hFF, 1'b1, 1'b0},
      '{"miss1",    8'h04, 8'hFF, 1'b1, 1'b0},
      '{"miss2",    8'h04, 8'hFF, 1'b1, 1'b0},
      '{"held0",    8'h03, 8'h11, 1'b1, 1'b1},
      '{"held1",    8'h03, 8'h22, 1'b1, 1'b1},
      '{"nordy",    8'h03, 8'h77, 1'b0, 1'b0},
      '{"msb_miss", 8'h83, 8'h99, 1'b1, 1'b0},
      '{"lsb_miss", 8'h02, 8'h98, 1'b1, 1'b0},
      '{"midaddr",  8'h07, 8'h44, 1'b1, 1'b0},
      '{"rehit",    8'h03, 8'hC3, 1'b1, 1'b1}
    };
    drive(ADDR, 8'h66, 1'b1);
    #2;
    rst = 1;
    #1;
    chk("reset data", data, RV);
    chk("reset ack", {7'd0, bus.si_ack}, 8'd0);
    drive(ADDR, 8'h66, 1'b0);
    #2;
    rst = 0;
    #1;
    chk("post-reset data", data, RV);
    model = RV;
    clk_en = 1;
    foreach (vecs[i]) step(vecs[i]);
    @(negedge clk);
    drive(ADDR, 8'h99, 1'b1);
    rst = 1;
    #1;
    chk("rstwr ack", {7'd0, bus.si_ack}, 8'd0);
    chk("rstwr async data", data, RV);
    @(posedge clk);
    #1;
    chk("rstwr edge data", data, RV);
    @(negedge clk);
    rst = 0;
    #1;
    chk("after rst ack", {7'd0, bus.si_ack}, 8'd1);
    @(posedge clk);
    #1;
    chk("after rst data", data, 8'h99);
    drive(ADDR, 8'h00, 1'b0);
    #2;
    chk("drop rdy ack", {7'd0, bus.si_ack}, 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
